// File: rtl/debounce_edge_pkg.sv
// Shared types for the debounce_edge block: FSM state encoding and the registered output bundle.
package debounce_edge_pkg;

    typedef enum logic [1:0] {
        ST_STABLE_LOW  = 2'd0,
        ST_SETTLE_HIGH = 2'd1,
        ST_STABLE_HIGH = 2'd2,
        ST_SETTLE_LOW  = 2'd3
    } state_t;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } edge_out_t;

    localparam edge_out_t EDGE_OUT_IDLE = '{level: 1'b0, rise: 1'b0, fall: 1'b0};

endpackage

// File: rtl/debounce_edge_if.sv
// Raw input and conditioned outputs of debounce_edge; slave is the conditioner, master the consumer.
interface debounce_edge_if;

    logic raw_in;
    logic level;
    logic rise;
    logic fall;

    modport slave (
        input  raw_in,
        output level,
        output rise,
        output fall
    );

    modport master (
        output raw_in,
        input  level,
        input  rise,
        input  fall
    );

endinterface

// File: rtl/debounce_edge_sync_chain.sv
// Reusable multi-flop synchronizer for an asynchronous single-bit input.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s <= '0;
        end else begin
            r_s <= {r_s[STAGES-2:0], d};
        end
    end

    assign q = r_s[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Debounces one raw input into a clean level plus single-cycle rise/fall pulses.
// Synchronizer feeds a four-state FSM with a stability counter; all outputs registered.
//
// state          | meaning
// ST_STABLE_LOW  | level is 0, synced input agrees
// ST_SETTLE_HIGH | synced input went 1, counting confirming cycles
// ST_STABLE_HIGH | level is 1, synced input agrees
// ST_SETTLE_LOW  | synced input went 0, counting confirming cycles
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    debounce_edge_if.slave bus
);

    localparam int CNT_BITS = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(STABLE_CYCLES);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    logic                w_sync;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_cnt_nxt;
    edge_out_t           r_out;
    edge_out_t           w_out_nxt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (bus.raw_in),
        .q     (w_sync)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_STABLE_LOW;
            r_cnt   <= '0;
            r_out   <= EDGE_OUT_IDLE;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
        end
    end

    // Counter saturates at CNT_MAX by construction: reaching it always leaves SETTLE.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = '0;
        w_out_nxt       = r_out;
        w_out_nxt.rise  = 1'b0;
        w_out_nxt.fall  = 1'b0;
        case (r_state)
            ST_STABLE_LOW: begin
                if (w_sync) begin
                    w_state_nxt = ST_SETTLE_HIGH;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_SETTLE_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = ST_STABLE_LOW;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt     = ST_STABLE_HIGH;
                    w_out_nxt.level = 1'b1;
                    w_out_nxt.rise  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_STABLE_HIGH: begin
                if (!w_sync) begin
                    w_state_nxt = ST_SETTLE_LOW;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            ST_SETTLE_LOW: begin
                if (w_sync) begin
                    w_state_nxt = ST_STABLE_HIGH;
                end else if (r_cnt == CNT_MAX) begin
                    w_state_nxt     = ST_STABLE_LOW;
                    w_out_nxt.level = 1'b0;
                    w_out_nxt.fall  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_STABLE_LOW;
            end
        endcase
    end

    assign bus.level = r_out.level;
    assign bus.rise  = r_out.rise;
    assign bus.fall  = r_out.fall;

endmodule

// File: tb/tb_debounce_edge.sv
// Bench for debounce_edge: two instances (STABLE_CYCLES 4 and 1) share stimulus and are
// compared every cycle against a run-length reference model, plus directed latency checks.
module tb_debounce_edge;

    localparam int SYNC = 2;
    localparam int THR0 = 4;
    localparam int THR1 = 1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic raw   = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    debounce_edge_if if0 ();
    debounce_edge_if if1 ();

    assign if0.raw_in = raw;
    assign if1.raw_in = raw;

    debounce_edge #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(THR0)) u_dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0.slave)
    );

    debounce_edge #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(THR1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1.slave)
    );

    // Reference model: raw history gives the synced value; a run of disagreeing synced
    // samples longer than the threshold flips the level and emits one pulse.
    bit m_hist[$];
    bit m_level[2];
    bit m_rise[2];
    bit m_fall[2];
    int m_run[2];
    int m_thr[2] = '{THR0, THR1};
    int press_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit s;
        if (reset) begin
            m_hist.delete();
            for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
            for (int d = 0; d < 2; d++) begin
                m_level[d] = 1'b0;
                m_rise[d]  = 1'b0;
                m_fall[d]  = 1'b0;
                m_run[d]   = 0;
            end
        end else begin
            s = m_hist[0];
            void'(m_hist.pop_front());
            m_hist.push_back(raw);
            for (int d = 0; d < 2; d++) begin
                m_rise[d] = 1'b0;
                m_fall[d] = 1'b0;
                m_run[d]  = (s != m_level[d]) ? m_run[d] + 1 : 0;
                if (m_run[d] == m_thr[d] + 1) begin
                    m_level[d] = s;
                    m_rise[d]  = s;
                    m_fall[d]  = !s;
                    m_run[d]   = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
        if (if0.rise === 1'b1) press_cnt++;
        check_val("dut0_out", {if0.level, if0.rise, if0.fall}, {m_level[0], m_rise[0], m_fall[0]});
        check_val("dut1_out", {if1.level, if1.rise, if1.fall}, {m_level[1], m_rise[1], m_fall[1]});
        check_val("dut0_excl", {31'd0, if0.rise & if0.fall}, 32'd0);
    endtask

    initial begin
        int cnt_before;
        int len;

        // 1: reset held with raw high, then one rise at sampling edge + 6 (dut1: + 3)
        raw   = 1'b1;
        reset = 1'b1;
        repeat (3) begin
            tick();
            check_val("rst_out", {if0.level, if0.rise, if0.fall}, 32'd0);
        end
        reset = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            check_val("t1_rise0", if0.rise, (j == 6));
            check_val("t1_rise1", if1.rise, (j == 3));
        end

        raw = 1'b0;
        repeat (10) tick();

        // 2: clean press
        raw = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            check_val("t2_rise0", if0.rise, (j == 6));
            check_val("t2_level0", if0.level, (j >= 6));
            check_val("t2_rise1", if1.rise, (j == 3));
        end

        raw = 1'b0;
        repeat (10) tick();

        // 3: bounce 3 high, 2 low, then steady high
        raw = 1'b1;
        repeat (3) begin
            tick();
            check_val("t3_bounce_rise", if0.rise, 32'd0);
        end
        raw = 1'b0;
        repeat (2) begin
            tick();
            check_val("t3_bounce_rise", if0.rise, 32'd0);
        end
        raw = 1'b1;
        for (int j = 0; j < 10; j++) begin
            tick();
            check_val("t3_rise0", if0.rise, (j == 6));
        end

        // 4: release from level 1
        raw = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            check_val("t4_fall0", if0.fall, (j == 6));
            check_val("t4_rise0", if0.rise, 32'd0);
            check_val("t4_level0", if0.level, (j < 6));
        end

        // 5: five clean presses advance a downstream counter by exactly five
        cnt_before = press_cnt;
        repeat (5) begin
            raw = 1'b1;
            repeat (9) tick();
            raw = 1'b0;
            repeat (9) tick();
        end
        check_val("t5_count", press_cnt - cnt_before, 32'd5);

        // 6: reset while level is high clears without a fall pulse
        raw = 1'b1;
        repeat (10) tick();
        check_val("t6_pre_level", if0.level, 32'd1);
        reset = 1'b1;
        tick();
        check_val("t6_level", if0.level, 32'd0);
        check_val("t6_fall", if0.fall, 32'd0);
        reset = 1'b0;
        raw   = 1'b0;
        repeat (8) tick();

        // Random runs of varying length, with occasional resets
        for (int r = 0; r < 400; r++) begin
            raw = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            repeat (len) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
